// File: rtl/mem_init_pkg.sv
// Shared types and helpers for the DDR bring-up sequencer.
package mem_init_pkg;

  localparam int unsigned STATE_W = 3;

  // Debug encoding of the sequencer state; IDLE is never entered in normal operation.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_ASSERT_RST = 3'd1,
    ST_WAIT_OK    = 3'd2,
    ST_STABLE     = 3'd3,
    ST_READY      = 3'd4,
    ST_FAIL       = 3'd5
  } state_e;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mem_init_sequencer.sv
// DDR bring-up sequencer: reset pulse, timed wait for mem_ok, stability window, bounded retries.
// Optional MEM_INIT_REARM_EN: automatic re-arm from READY when mem_ok drops for two cycles.
module mem_init_sequencer
  import mem_init_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 24
) (
  input  logic                                        clock,
  input  logic                                        aresetn,
  input  logic                                        start,
  input  logic                                        mem_ok,
  output logic                                        mem_sys_reset,
  output logic                                        busy,
  output logic                                        ready,
  output logic                                        fail,
  output logic [clog2_min1(MAX_RETRIES + 1)-1:0]      retry_count,
  output logic [STATE_W-1:0]                          state
`ifdef MEM_INIT_REARM_EN
  ,
  output logic                                        rearmed
`endif
);

  localparam int unsigned RC_W = clog2_min1(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX    = RC_W'(MAX_RETRIES);

  logic             w_ok_s;
  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [RC_W-1:0]  r_retry;
  logic [RC_W-1:0]  w_retry_next;
  logic             r_mem_sys_reset;
  logic             r_busy;
  logic             r_ready;
  logic             r_fail;
  logic             w_msr_next;
  logic             w_busy_next;
  logic             w_ready_next;
  logic             w_fail_next;
`ifdef MEM_INIT_REARM_EN
  logic             r_ok_low;
  logic             w_ok_low_next;
  logic             r_rearmed;
  logic             w_rearm;
`endif

  sync_2ff #(.WIDTH(1)) u_sync_mem_ok (
    .clk   (clock),
    .rst_n (aresetn),
    .i_d   (mem_ok),
    .o_q   (w_ok_s)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_retry_next = r_retry;
`ifdef MEM_INIT_REARM_EN
    w_ok_low_next = 1'b0;
    w_rearm       = 1'b0;
`endif
    case (r_state)
      ST_ASSERT_RST: begin
        if (r_cnt == RST_LAST) begin
          w_cnt_next   = '0;
          w_next_state = ST_WAIT_OK;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_OK: begin
        if (w_ok_s) begin
          w_cnt_next   = '0;
          w_next_state = ST_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_next = r_retry + RC_W'(1);
            w_cnt_next   = '0;
            w_next_state = ST_ASSERT_RST;
          end else begin
            w_next_state = ST_FAIL;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!w_ok_s) begin
          w_cnt_next   = '0;
          w_next_state = ST_WAIT_OK;
        end else if (r_cnt == STABLE_LAST) begin
          w_cnt_next   = '0;
          w_next_state = ST_READY;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_READY: begin
        if (start) begin
          w_retry_next = '0;
          w_cnt_next   = '0;
          w_next_state = ST_ASSERT_RST;
        end
`ifdef MEM_INIT_REARM_EN
        // Two consecutive low samples of ok_s restart bring-up automatically.
        else if (!w_ok_s) begin
          if (r_ok_low) begin
            w_retry_next = '0;
            w_cnt_next   = '0;
            w_next_state = ST_ASSERT_RST;
            w_rearm      = 1'b1;
          end else begin
            w_ok_low_next = 1'b1;
          end
        end
`endif
      end
      ST_FAIL: begin
        if (start) begin
          w_retry_next = '0;
          w_cnt_next   = '0;
          w_next_state = ST_ASSERT_RST;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_next_state = ST_ASSERT_RST;
      end
    endcase

    w_msr_next   = (w_next_state == ST_ASSERT_RST) || (w_next_state == ST_FAIL);
    w_busy_next  = (w_next_state == ST_ASSERT_RST) || (w_next_state == ST_WAIT_OK) ||
                   (w_next_state == ST_STABLE);
    w_ready_next = (w_next_state == ST_READY);
    w_fail_next  = (w_next_state == ST_FAIL);
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= ST_ASSERT_RST;
      r_cnt           <= '0;
      r_retry         <= '0;
      r_mem_sys_reset <= 1'b1;
      r_busy          <= 1'b1;
      r_ready         <= 1'b0;
      r_fail          <= 1'b0;
`ifdef MEM_INIT_REARM_EN
      r_ok_low        <= 1'b0;
      r_rearmed       <= 1'b0;
`endif
    end else begin
      r_state         <= w_next_state;
      r_cnt           <= w_cnt_next;
      r_retry         <= w_retry_next;
      r_mem_sys_reset <= w_msr_next;
      r_busy          <= w_busy_next;
      r_ready         <= w_ready_next;
      r_fail          <= w_fail_next;
`ifdef MEM_INIT_REARM_EN
      r_ok_low        <= w_ok_low_next;
      r_rearmed       <= w_rearm;
`endif
    end
  end

  assign mem_sys_reset = r_mem_sys_reset;
  assign busy          = r_busy;
  assign ready         = r_ready;
  assign fail          = r_fail;
  assign retry_count   = r_retry;
  assign state         = r_state;
`ifdef MEM_INIT_REARM_EN
  assign rearmed       = r_rearmed;
`endif

endmodule

// File: doc/mem_init_sequencer.md
Name: mem_init_sequencer

Overview:
Sequences bring-up of the DDR memory subsystem. Drives the memory reset-control block's `sys_reset` input and watches its `mem_ok` status. Applies a timeout to each bring-up attempt and retries a bounded number of times. Publishes `ready`/`fail` status to the rest of the SoC (boot ROM gating, LED/status register). Lives in the board-level `clock` domain, beside the memory reset control.

Parameters:
RST_CYCLES, 64, cycles `mem_sys_reset` is held high per attempt (min 1)
TIMEOUT_CYCLES, 2000000, max cycles to wait for synchronized `mem_ok` per attempt (min 1)
STABLE_CYCLES, 256, consecutive cycles `mem_ok` must stay high before `ready` (min 1)
MAX_RETRIES, 3, extra attempts after the first before declaring failure (0 = single attempt)
CNT_W, 24, width of the shared cycle counter; must hold max(RST_CYCLES, TIMEOUT_CYCLES, STABLE_CYCLES)

Ports:
clock  input  1  system clock
aresetn  input  1  one clock; reset is asynchronous and active-low
start  input  1  single-cycle pulse; restarts the sequence from FAIL or READY
mem_ok  input  1  memory subsystem healthy; asynchronous to `clock` (ui_clk domain)
mem_sys_reset  output  1  active-high reset request to memory reset control
busy  output  1  sequence in progress (ASSERT_RST, WAIT_OK, STABLE)
ready  output  1  memory usable
fail  output  1  all attempts exhausted
retry_count  output  $clog2(MAX_RETRIES+1) (min 1)  retries consumed in the current sequence
state  output  3  current FSM state encoding, for debug

Behaviour:
- `mem_ok` passes through a 2-flop synchronizer (ASYNC_REG). The name `ok_s` below means the synchronized value. Synchronizer flops reset to 0.
- Async reset values:
  - state = ASSERT_RST, cnt = 0, retry_count = 0
  - `mem_sys_reset` = 1, `busy` = 1, `ready` = 0, `fail` = 0
- All outputs are registered, with no combinational path from inputs.
- State encoding, in the team package: IDLE=0, ASSERT_RST=1, WAIT_OK=2, STABLE=3, READY=4, FAIL=5. IDLE is unused in normal operation.
- ASSERT_RST:
  - `mem_sys_reset` = 1; cnt increments each cycle.
  - When cnt == RST_CYCLES-1: cnt <= 0, go to WAIT_OK.
  - Net effect: `mem_sys_reset` is high for exactly RST_CYCLES cycles.
- WAIT_OK:
  - `mem_sys_reset` = 0.
  - If `ok_s` = 1: cnt <= 0, go to STABLE.
  - Else if cnt == TIMEOUT_CYCLES-1, timeout:
    - If retry_count < MAX_RETRIES: retry_count++, cnt <= 0, go to ASSERT_RST.
    - Otherwise go to FAIL.
  - Else cnt++.
  - `ok_s` and timeout in the same cycle: `ok_s` wins.
- STABLE:
  - If `ok_s` = 0: cnt <= 0, return to WAIT_OK. The timeout restarts; no retry is consumed.
  - Else if cnt == STABLE_CYCLES-1: go to READY.
  - Else cnt++.
- READY:
  - `ready` = 1, `busy` = 0.
  - Holds regardless of `ok_s` (but see the optional feature).
- FAIL:
  - `fail` = 1, `busy` = 0, `mem_sys_reset` = 1. The memory is held in reset.
- `start` handling:
  - `start` = 1 in READY or FAIL: retry_count <= 0, cnt <= 0, go to ASSERT_RST.
  - `start` is ignored in ASSERT_RST, WAIT_OK and STABLE.
- `ready` and `fail` are never high together. Both deassert in the cycle after leaving READY/FAIL.
- retry_count saturates at MAX_RETRIES and is not cleared on reaching READY; it stays readable.
- Counter arithmetic is unsigned CNT_W bits. Terminal comparisons use ==, so the counter never wraps.

Optional Feature:
MEM_INIT_REARM_EN
- Defined: in READY, `ok_s` = 0 for 2 consecutive cycles forces `ready` low and re-enters ASSERT_RST with retry_count cleared. This is the automatic recovery path after a memory controller reset.
- An extra 1-bit output `rearmed` pulses high for 1 cycle on each such event.
- Not defined: READY is sticky until `start` or reset, and the `rearmed` port does not exist.

Decomposition:
- Package `mem_init_pkg`: state enum/localparams, state width (3), debug encoding constants.
- One sub-module is natural: `sync_2ff` (generic 2-flop synchronizer, async active-low reset, ASYNC_REG), instanced for `mem_ok`.
- The FSM and counter stay in the top module.

Test Plan:
Bench parameters: RST_CYCLES=4, TIMEOUT_CYCLES=16, STABLE_CYCLES=3, MAX_RETRIES=2.
1. Release `aresetn`; drive `mem_ok`=1 from cycle 6.
   -> `mem_sys_reset` high for exactly 4 cycles; `ready`=1 after synchronizer + 3 stable cycles; retry_count=0; `fail`=0.
2. Keep `mem_ok`=0 throughout.
   -> 3 reset pulses of 4 cycles each, spaced by 16-cycle waits; retry_count goes 1 then 2; then `fail`=1, `mem_sys_reset`=1, `busy`=0.
3. From FAIL, raise `mem_ok`=1 and pulse `start`.
   -> retry_count=0, new 4-cycle reset pulse, `fail` drops the next cycle, reaches `ready`.
4. In STABLE, drop `mem_ok` for 1 cycle after 2 stable cycles.
   -> returns to WAIT_OK, no retry consumed, `ready` is delayed by a full new 3-cycle stable window.
5. Assert `aresetn` mid-WAIT_OK.
   -> outputs immediately take reset values (`mem_sys_reset`=1, `busy`=1, `ready`=0).
6. With MEM_INIT_REARM_EN, drop `mem_ok` for 2 cycles in READY.
   -> `rearmed` pulses once, `ready`=0, new reset sequence runs.
   - Without the macro: `ready` stays 1.
